// File: rtl/arm_pkg.sv
// Shared types and constants for the ARM fetch stage and its helpers.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package arm_pkg;

    localparam int              WORD_W    = 32;
    localparam logic [31:0]     PC_INC    = 32'd4;
    localparam logic [31:0]     NOP_INSTR = 32'd0;

    // Contents of the IF/ID pipeline register.
    typedef struct packed {
        logic [WORD_W-1:0] pc;      // PC+4 of the held instruction
        logic [WORD_W-1:0] instru;  // held instruction word
        logic              valid;   // 0 = bubble
    } if_id_t;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;

    // Instruction addresses are word aligned; the low two bits of a
    // redirect target carry no meaning and are dropped.
    function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] a);
        return {a[WORD_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/arm_fetch_stage_if.sv
// Bundle of fetch-stage control, instruction-memory and IF/ID signals.
// Latency: none (wiring only).
// Backpressure: freeze from the hazard unit is the only stall input.
// Ports (slave = fetch stage side):
//   in : freeze, branch_taken, branch_addr, imem_instru
//   out: imem_addr, if_id_pc, if_id_instru, if_id_valid, fetch_cnt, flush_cnt
interface arm_fetch_if #(
    parameter int CNT_W = 32
);
    import arm_pkg::*;

    logic              freeze;
    logic              branch_taken;
    logic [WORD_W-1:0] branch_addr;
    logic [WORD_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_instru;
    logic [WORD_W-1:0] if_id_pc;
    logic [WORD_W-1:0] if_id_instru;
    logic              if_id_valid;
    logic [CNT_W-1:0]  fetch_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    // Environment side: hazard unit, execute stage, instruction memory, decode.
    modport master (
        output freeze, branch_taken, branch_addr, imem_instru,
        input  imem_addr, if_id_pc, if_id_instru, if_id_valid, fetch_cnt, flush_cnt
    );

    // Fetch stage side.
    modport slave (
        input  freeze, branch_taken, branch_addr, imem_instru,
        output imem_addr, if_id_pc, if_id_instru, if_id_valid, fetch_cnt, flush_cnt
    );

endinterface

// File: rtl/arm_pc_reg.sv
// Program counter register with +4 increment and branch redirect mux.
// Latency: new PC visible one edge after the request; pc_o is the register itself.
// Backpressure: freeze_i holds the PC unless a branch redirect is present.
// Ports: clk, rst_n; freeze_i, branch_taken_i, branch_addr_i in;
//        pc_o (current PC), pc_inc_o (PC+4, modulo 2^32) out.
module arm_pc_reg
    import arm_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'd0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze_i,
    input  logic              branch_taken_i,
    input  logic [WORD_W-1:0] branch_addr_i,
    output logic [WORD_W-1:0] pc_o,
    output logic [WORD_W-1:0] pc_inc_o
);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;

    // Natural 32-bit overflow gives the required wrap from FFFF_FFFC to 0.
    assign pc_inc_o = pc_q + PC_INC;
    assign pc_o     = pc_q;

    // Redirect beats freeze: a taken branch must never be lost to a stall.
    always_comb begin
        pc_d = pc_q;
        if (branch_taken_i) begin
            pc_d = align_word(branch_addr_i);
        end else if (!freeze_i) begin
            pc_d = pc_inc_o;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: rtl/arm_fetch_stage.sv
// Instruction fetch: PC drives combinational imem, returned word registered into IF/ID.
// Latency: 1 edge PC->IF/ID; a taken branch inserts exactly one bubble.
// Backpressure: freeze holds PC, IF/ID and counters; branch_taken overrides freeze.
// Ports: clk, rst_n (async active-low); bus (arm_fetch_if.slave) carrying
//        freeze/branch_taken/branch_addr/imem_instru in and
//        imem_addr/if_id_pc/if_id_instru/if_id_valid/fetch_cnt/flush_cnt out.
module arm_fetch_stage
    import arm_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 32'd0,
    parameter int                CNT_W    = 32
) (
    input  logic      clk,
    input  logic      rst_n,
    arm_fetch_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] pc_inc;

    if_id_t            if_id_q;
    if_id_t            if_id_d;
    logic [CNT_W-1:0]  fetch_cnt_q;
    logic [CNT_W-1:0]  fetch_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_d;
    fetch_state_t      state_q;
    fetch_state_t      state_d;
    logic              in_hold;
    logic              advance;

    arm_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk            (clk),
        .rst_n          (rst_n),
        .freeze_i       (bus.freeze),
        .branch_taken_i (bus.branch_taken),
        .branch_addr_i  (bus.branch_addr),
        .pc_o           (pc),
        .pc_inc_o       (pc_inc)
    );

    assign advance = !bus.branch_taken && !bus.freeze;

    // ------------------------------------------------------------------
    // IF/ID register and statistics
    // ------------------------------------------------------------------
    always_comb begin
        if_id_d     = if_id_q;
        fetch_cnt_d = fetch_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (bus.branch_taken) begin
            // The word fetched this cycle is on the wrong path: squash it.
            if_id_d.pc     = '0;
            if_id_d.instru = NOP_INSTR;
            if_id_d.valid  = 1'b0;
            flush_cnt_d    = (flush_cnt_q == CNT_MAX) ? flush_cnt_q : flush_cnt_q + CNT_ONE;
        end else if (advance) begin
            if_id_d.pc     = pc_inc;
            if_id_d.instru = bus.imem_instru;
            if_id_d.valid  = 1'b1;
            fetch_cnt_d    = (fetch_cnt_q == CNT_MAX) ? fetch_cnt_q : fetch_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_q     <= '0;
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if_id_q     <= if_id_d;
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // RUN/HOLD state machine: observability only, drives no port.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (bus.freeze && !bus.branch_taken) state_d = HOLD;
            HOLD:    if (!bus.freeze || bus.branch_taken) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        in_hold = (state_q == HOLD);
    end

    // Being in HOLD means the last edge was a pure freeze, so IF/ID and the
    // PC must not have moved across it.
    a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        in_hold |-> ($stable(if_id_q) && $stable(pc)));

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.imem_addr    = pc;
    assign bus.if_id_pc     = if_id_q.pc;
    assign bus.if_id_instru = if_id_q.instru;
    assign bus.if_id_valid  = if_id_q.valid;
    assign bus.fetch_cnt    = fetch_cnt_q;
    assign bus.flush_cnt    = flush_cnt_q;

endmodule

// File: tb/tb_arm_fetch_stage.sv
// Self-checking bench for arm_fetch_stage against a behavioural fetch model.
// Latency: checks one time unit after each rising edge.
// Backpressure: exercises freeze, branch, freeze+branch and mid-cycle reset.
module tb_arm_fetch_stage;

    localparam int          CW    = 4;        // small counters so saturation is reachable
    localparam logic [31:0] RST_PC = 32'd0;

    logic clk;
    logic rst_n;

    arm_fetch_if #(.CNT_W(CW)) bus();

    arm_fetch_stage #(
        .RESET_PC (RST_PC),
        .CNT_W    (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational instruction memory: a few fixed words, some zero words,
    // and a scrambled pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'd0) return 32'hE3A0_0014;
        if (a == 32'd4) return 32'hE3A0_1A01;
        if (a == 32'd8) return 32'hE3A0_2103;
        if (a[6:0] == 7'h20) return 32'd0;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    assign bus.imem_instru = mem_word(bus.imem_addr);

    // Reference model state.
    logic [31:0] m_pc;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_ins;
    logic        m_if_vld;
    int          m_fetch;
    int          m_flush;

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc     = RST_PC;
        m_if_pc  = 32'd0;
        m_if_ins = 32'd0;
        m_if_vld = 1'b0;
        m_fetch  = 0;
        m_flush  = 0;
    endtask

    task automatic check_all(input string where);
        chk({where, ":imem_addr"},    bus.imem_addr,               m_pc);
        chk({where, ":if_id_pc"},     bus.if_id_pc,                m_if_pc);
        chk({where, ":if_id_instru"}, bus.if_id_instru,            m_if_ins);
        chk({where, ":if_id_valid"},  {31'd0, bus.if_id_valid},    {31'd0, m_if_vld});
        chk({where, ":fetch_cnt"},    {{(32-CW){1'b0}}, bus.fetch_cnt}, m_fetch);
        chk({where, ":flush_cnt"},    {{(32-CW){1'b0}}, bus.flush_cnt}, m_flush);
    endtask

    // One clock cycle: drive inputs (optionally glitching freeze between
    // edges), take the edge, advance the model, compare.
    task automatic step(input string where, input bit fr, input bit br,
                        input logic [31:0] ba, input bit glitch);
        bus.branch_taken = br;
        bus.branch_addr  = ba;
        if (glitch) begin
            bus.freeze = !fr;
            #2;
        end
        bus.freeze = fr;
        @(posedge clk);
        if (br) begin
            m_pc     = ba & 32'hFFFF_FFFC;
            m_if_pc  = 32'd0;
            m_if_ins = 32'd0;
            m_if_vld = 1'b0;
            if (m_flush < (1 << CW) - 1) m_flush++;
        end else if (!fr) begin
            m_if_ins = mem_word(m_pc);
            m_pc     = m_pc + 32'd4;
            m_if_pc  = m_pc;
            m_if_vld = 1'b1;
            if (m_fetch < (1 << CW) - 1) m_fetch++;
        end
        #1;
        check_all(where);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        bus.freeze       = 1'b0;
        bus.branch_taken = 1'b0;
        bus.branch_addr  = 32'd0;
        rst_n            = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        #6;
        rst_n = 1'b1;   // released mid-cycle at t=8

        // Free-running from RESET_PC.
        step("run0", 0, 0, 32'd0, 0);
        step("run1", 0, 0, 32'd0, 0);
        step("run2", 0, 0, 32'd0, 0);
        chk("run_instru_first_word", 32'hE3A0_2103, m_if_ins);

        // Freeze two cycles at PC=12, then release.
        step("frz0", 1, 0, 32'd0, 0);
        step("frz1", 1, 0, 32'd0, 0);
        step("frz_rel", 0, 0, 32'd0, 0);
        chk("frz_rel_pc16", bus.if_id_pc, 32'd16);

        // Bring PC to 148, then redirect to 0x67 -> 0x64.
        step("br144", 0, 1, 32'd144, 0);
        step("run148", 0, 0, 32'd0, 0);
        step("br67", 0, 1, 32'h0000_0067, 0);
        chk("br67_imem", bus.imem_addr, 32'h64);
        step("after_br", 0, 0, 32'd0, 0);
        chk("after_br_pc", bus.if_id_pc, 32'h68);

        // Freeze and branch together: branch wins.
        step("frz_br", 1, 1, 32'h40, 0);

        // PC wrap from FFFF_FFFC.
        step("br_top", 0, 1, 32'hFFFF_FFFE, 0);
        step("wrap", 0, 0, 32'd0, 0);
        chk("wrap_imem", bus.imem_addr, 32'd0);

        // Fetch through a zero instruction word (address 0x20).
        step("br_zero", 0, 1, 32'h20, 0);
        step("zero_word", 0, 0, 32'd0, 0);

        // Randomized traffic with glitches on freeze between edges.
        for (int i = 0; i < 300; i++) begin
            bit fr;
            bit br;
            logic [31:0] ba;
            fr = ($urandom_range(0, 9) < 3);
            br = ($urandom_range(0, 9) < 2);
            ba = $urandom;
            if ($urandom_range(0, 3) == 0) ba = ba & 32'h0000_00FF;
            step("rand", fr, br, ba, ($urandom_range(0, 4) == 0));
        end

        // Asynchronous reset while frozen, in the middle of a cycle.
        bus.freeze = 1'b1;
        @(posedge clk);
        #1;
        check_all("pre_rst_freeze");
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_rst");
        #2;
        rst_n = 1'b1;
        step("post_rst0", 0, 0, 32'd0, 0);
        chk("post_rst_word", bus.if_id_instru, 32'hE3A0_0014);
        for (int i = 0; i < 40; i++) begin
            step("rand2", ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 2),
                 $urandom, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
